present_enc_core: RTL and testbench
===================================

Name: present_enc_core

Overview:
- PRESENT-80 encryption datapath plus control FSM; sits directly downstream of key_schedule and consumes its round_key.
- Drives key_schedule's load_key, update_key and round_counter.
- Holds the 64-bit cipher state and performs 31 rounds of addRoundKey, sLayer and pLayer, then a final key whitening.
- At top level the 80-bit key is wired straight into key_schedule.key_input; this block never sees the key.

Parameters:
NUM_ROUNDS, 31, number of full rounds; PRESENT compliance requires 31, and other values are for debug only.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request an encryption; sampled only in IDLE
plaintext  input  64  block to encrypt; captured on the accepting edge
ks_round_key  input  64  current round key from key_schedule
ks_load_key  output  1  key_schedule load strobe
ks_update_key  output  1  key_schedule advance strobe
ks_round_counter  output  5  round index for the key_schedule update
busy  output  1  high from the accept edge until the done edge
done  output  1  one-cycle pulse, ciphertext valid
ciphertext  output  64  result; holds until the next done

Behaviour:
- Reset: already decided — one clock (clk); reset rst is asynchronous and active-high.
  - While rst is high: FSM = IDLE, state_reg = 0, round = 0, ciphertext = 0, busy = 0, done = 0.
  - ks_load_key = 0, ks_update_key = 0, ks_round_counter = 0.
- FSM states: IDLE, LOAD, ROUND, FINAL.
- IDLE:
  - If start = 1 at an edge: state_reg <= plaintext, busy <= 1, next state LOAD.
  - Otherwise stay in IDLE.
- LOAD (exactly 1 cycle):
  - ks_load_key = 1, combinational from the state.
  - The key register loads at the exit edge; round <= 1; next state ROUND.
- ROUND (NUM_ROUNDS cycles):
  - ks_update_key = 1 and ks_round_counter = round, both combinational.
  - At each edge: state_reg <= pLayer(sLayer(state_reg ^ ks_round_key)) and round <= round + 1.
  - When round = NUM_ROUNDS the edge goes to FINAL instead.
- FINAL (1 cycle):
  - At the edge: ciphertext <= state_reg ^ ks_round_key (this is K32), done <= 1, busy <= 0, next state IDLE.
- done is registered and high for exactly one cycle, the first IDLE cycle.
- Latency: with start sampled at edge E0, done and ciphertext are valid after edge E0+NUM_ROUNDS+2 (E33 by default). Throughput is one block per 34 cycles.
- sLayer: 16 parallel 4-bit PRESENT S-boxes, table C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 (so F->2).
- pLayer: bit i moves to bit (16*i) mod 63 for i < 63; bit 63 stays at 63.
- ks_round_counter is 0 outside ROUND. In ROUND it takes values 1..31 and never wraps.
- Boundary conditions:
  - start while busy is ignored; plaintext changes while busy are ignored.
  - start in the cycle done is high is accepted, since the FSM is already in IDLE.
  - rst mid-operation aborts immediately. ciphertext clears to 0 and no done is issued. key_schedule must be reloaded, which the next LOAD does.
  - ks_load_key and ks_update_key are never high in the same cycle.

Decomposition:
- Package present_pkg holds:
  - state-encoding localparams: IDLE = 2'd0, LOAD = 2'd1, ROUND = 2'd2, FINAL = 2'd3;
  - PRESENT_ROUNDS = 31, STATE_W = 64, KEY_W = 80;
  - the pLayer permutation function.
- One sub-module: present_sp_layer, combinational 64-bit in to 64-bit out. It is 16 instances of the existing sbox followed by the pLayer wiring, and is reusable by a future decrypt core.

Test Plan:
- Key 0x0000…, plaintext 0x0000000000000000 -> ciphertext 5579C1387B228445, done after 33 edges.
- Key 0x0000…, plaintext 0xFFFFFFFFFFFFFFFF -> A112FFC72F68417B.
- Key 0xFFFF…, plaintext 0x0000000000000000 -> E72C46C0F5945049.
- Key 0xFFFF…, plaintext 0xFFFFFFFFFFFFFFFF -> 3333DCD3213210D2. Pulse start again in the done cycle; the second result is identical and ks_load_key fires again.
- Protocol check:
  - ks_load_key is high exactly 1 cycle;
  - ks_update_key is high 31 cycles with ks_round_counter 1..31;
  - start pulses during busy have no effect;
  - busy falls together with the done edge.
- Assert rst at round 10 -> all outputs 0 immediately (asynchronous). Release and restart with vector 1 -> 5579C1387B228445.

Source files
------------

// File: rtl/present_pkg.sv
// Shared definitions for the PRESENT-80 cipher blocks: FSM encodings,
// datapath widths and the bit permutation used by the substitution/permutation layer.
package present_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] ROUND = 2'd2;
  localparam logic [1:0] FINAL = 2'd3;

  localparam int PRESENT_ROUNDS = 31;
  localparam int STATE_W        = 64;
  localparam int KEY_W          = 80;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_LOAD  = LOAD,
    ST_ROUND = ROUND,
    ST_FINAL = FINAL
  } fsm_state_t;

  // Bit i moves to (16*i) mod 63; the top bit is a fixed point.
  function automatic logic [STATE_W-1:0] p_layer(input logic [STATE_W-1:0] din);
    logic [STATE_W-1:0] dout;
    dout = '0;
    for (int i = 0; i < STATE_W - 1; i++) begin
      dout[(16 * i) % 63] = din[i];
    end
    dout[STATE_W-1] = din[STATE_W-1];
    return dout;
  endfunction

endpackage

// File: rtl/present_sp_layer.sv
// PRESENT substitution/permutation layer: 16 parallel 4-bit S-boxes followed
// by the fixed bit permutation. Purely combinational.
module present_sbox (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  always_comb begin
    dout = 4'h0;
    case (din)
      4'h0: dout = 4'hC;
      4'h1: dout = 4'h5;
      4'h2: dout = 4'h6;
      4'h3: dout = 4'hB;
      4'h4: dout = 4'h9;
      4'h5: dout = 4'h0;
      4'h6: dout = 4'hA;
      4'h7: dout = 4'hD;
      4'h8: dout = 4'h3;
      4'h9: dout = 4'hE;
      4'hA: dout = 4'hF;
      4'hB: dout = 4'h8;
      4'hC: dout = 4'h4;
      4'hD: dout = 4'h7;
      4'hE: dout = 4'h1;
      4'hF: dout = 4'h2;
      default: dout = 4'h0;
    endcase
  end
endmodule

module present_sp_layer
  import present_pkg::*;
(
  input  logic [STATE_W-1:0] din,
  output logic [STATE_W-1:0] dout
);
  logic [STATE_W-1:0] s_out;

  for (genvar g = 0; g < STATE_W / 4; g++) begin : g_sbox
    present_sbox u_sbox (
      .din  (din[4*g +: 4]),
      .dout (s_out[4*g +: 4])
    );
  end

  assign dout = p_layer(s_out);
endmodule

// File: rtl/present_enc_core.sv
// PRESENT-80 encryption datapath and control; steers an external key_schedule
// through load/update strobes and consumes its round key each cycle.
module present_enc_core
  import present_pkg::*;
#(
  parameter int NUM_ROUNDS = PRESENT_ROUNDS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STATE_W-1:0] plaintext,
  input  logic [STATE_W-1:0] ks_round_key,
  output logic               ks_load_key,
  output logic               ks_update_key,
  output logic [4:0]         ks_round_counter,
  output logic               busy,
  output logic               done,
  output logic [STATE_W-1:0] ciphertext,
  output logic [1:0]         fsm_state
);
  // Handshake: start is a request sampled only while IDLE (no back-pressure);
  // done is a one-cycle registered pulse marking ciphertext valid, and
  // ciphertext then holds until the next done.
  localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS);

  fsm_state_t         state_q, state_d;
  logic [4:0]         round_q;
  logic [STATE_W-1:0] state_reg;
  logic [STATE_W-1:0] sp_out;

  present_sp_layer u_sp_layer (
    .din  (state_reg ^ ks_round_key),
    .dout (sp_out)
  );

  always_comb begin
    state_d          = state_q;
    ks_load_key      = 1'b0;
    ks_update_key    = 1'b0;
    ks_round_counter = 5'd0;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        ks_load_key = 1'b1;
        state_d     = ST_ROUND;
      end
      ST_ROUND: begin
        ks_update_key    = 1'b1;
        ks_round_counter = round_q;
        if (round_q == LAST_ROUND) state_d = ST_FINAL;
      end
      ST_FINAL: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign fsm_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      round_q    <= 5'd0;
      state_reg  <= '0;
      ciphertext <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_reg <= plaintext;
            busy      <= 1'b1;
          end
        end
        ST_LOAD: round_q <= 5'd1;
        ST_ROUND: begin
          state_reg <= sp_out;
          // Counter parks at 0 after the last round so it never wraps visibly.
          round_q   <= (round_q == LAST_ROUND) ? 5'd0 : round_q + 5'd1;
        end
        ST_FINAL: begin
          ciphertext <= state_reg ^ ks_round_key;
          done       <= 1'b1;
          busy       <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_present_enc_core.sv
// Bench for present_enc_core: a behavioural PRESENT-80 key schedule feeds the
// core, directed vectors drive it, and a monitor scores ciphertext on done.
module tb_present_enc_core;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] plaintext;
  logic [63:0] ks_round_key;
  logic        ks_load_key;
  logic        ks_update_key;
  logic [4:0]  ks_round_counter;
  logic        busy;
  logic        done;
  logic [63:0] ciphertext;
  logic [1:0]  fsm_state;

  logic [79:0] key_in;
  logic [79:0] ks_key;
  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_err    = 0;

  localparam logic [79:0] K_ZERO = 80'h0;
  localparam logic [79:0] K_ONES = {80{1'b1}};
  localparam logic [63:0] P_ZERO = 64'h0;
  localparam logic [63:0] P_ONES = {64{1'b1}};

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, expected finish before 200000ns");
    $fatal(1, "global timeout");
  end

  present_enc_core #(.NUM_ROUNDS(31)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .plaintext        (plaintext),
    .ks_round_key     (ks_round_key),
    .ks_load_key      (ks_load_key),
    .ks_update_key    (ks_update_key),
    .ks_round_counter (ks_round_counter),
    .busy             (busy),
    .done             (done),
    .ciphertext       (ciphertext),
    .fsm_state        (fsm_state)
  );

  // ---------------- key schedule model ----------------
  function automatic logic [3:0] sbox_ref(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  function automatic logic [79:0] ks_next(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] t;
    t          = {k[18:0], k[79:19]};
    t[79:76]   = sbox_ref(t[79:76]);
    t[19:15]   = t[19:15] ^ rc;
    return t;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst)                ks_key <= '0;
    else if (ks_load_key)   ks_key <= key_in;
    else if (ks_update_key) ks_key <= ks_next(ks_key, ks_round_counter);
  end
  assign ks_round_key = ks_key[79:16];

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_done: got ciphertext %h expected no done", ciphertext);
      end else begin
        chk("ciphertext", ciphertext, exp_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  // Caller is at a negedge with the core in IDLE; returns at the negedge
  // where done is visible.
  task automatic encrypt(input logic [79:0] key, input logic [63:0] pt, input logic [63:0] exp);
    int cyc, loads, updates, ctr_bad, both;
    key_in = key; plaintext = pt; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_q.push_back(exp);
    chk("busy_after_accept", 64'(busy), 64'd1);
    chk("done_one_cycle", 64'(done), 64'd0);
    cyc = 0; loads = 0; updates = 0; ctr_bad = 0; both = 0;
    while (done !== 1'b1 && cyc < 100) begin
      if (ks_load_key) loads++;
      if (ks_update_key) begin
        updates++;
        if (ks_round_counter !== 5'(updates)) ctr_bad++;
      end
      if (ks_load_key && ks_update_key) both++;
      if (cyc == 5) begin
        start = 1'b1;
        plaintext = {$urandom, $urandom};
      end
      if (cyc == 6) start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("latency", 64'(cyc), 64'd33);
    chk("load_cycles", 64'(loads), 64'd1);
    chk("update_cycles", 64'(updates), 64'd31);
    chk("round_counter_seq_errs", 64'(ctr_bad), 64'd0);
    chk("load_update_overlap", 64'(both), 64'd0);
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("counter_idle", 64'(ks_round_counter), 64'd0);
  endtask

  task automatic abort_at_round10(input logic [79:0] key, input logic [63:0] pt);
    int cyc;
    key_in = key; plaintext = pt; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (ks_round_counter !== 5'd10 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_round10", 64'(ks_round_counter), 64'd10);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_ciphertext", ciphertext, 64'd0);
    chk("abort_load", 64'(ks_load_key), 64'd0);
    chk("abort_update", 64'(ks_update_key), 64'd0);
    chk("abort_counter", 64'(ks_round_counter), 64'd0);
    chk("abort_state", 64'(fsm_state), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; plaintext = '0; key_in = '0;
    #1;
    chk("reset_ciphertext", ciphertext, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_state", 64'(fsm_state), 64'd0);
    chk("reset_strobes", 64'({ks_load_key, ks_update_key}), 64'd0);
    chk("reset_counter", 64'(ks_round_counter), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    encrypt(K_ZERO, P_ZERO, 64'h5579C1387B228445);
    @(negedge clk);
    encrypt(K_ZERO, P_ONES, 64'hA112FFC72F68417B);
    @(negedge clk);
    encrypt(K_ONES, P_ZERO, 64'hE72C46C0F5945049);
    @(negedge clk);
    encrypt(K_ONES, P_ONES, 64'h3333DCD3213210D2);
    // start again in the done cycle
    encrypt(K_ONES, P_ONES, 64'h3333DCD3213210D2);
    @(negedge clk);
    chk("done_cleared", 64'(done), 64'd0);

    abort_at_round10(K_ONES, P_ONES);
    encrypt(K_ZERO, P_ZERO, 64'h5579C1387B228445);

    repeat (5) @(negedge clk);
    chk("ciphertext_hold", ciphertext, 64'h5579C1387B228445);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end
endmodule
